// File: rtl/demux16_route_ctrl.sv
// Valid/ready sequencer for the 1x16 demux: addressed or round-robin routing, one word held at a time.
// Optional stall watchdog enabled by defining DEMUX_WDT_EN.
module demux16_route_ctrl #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [3:0]    in_dest,
  input  logic          mode,
  output logic [15:0]   out_valid,
  input  logic [15:0]   out_ready,
  output logic [DW-1:0] out_data,
  output logic [3:0]    sel,
  output logic          busy,
  output logic [15:0]   word_cnt,
  output logic          drop
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_DRIVE = 1'b1;

  logic [0:0] state;
  logic [3:0] rr_ptr;
  logic       hs, accept;

  assign busy     = (state == S_DRIVE);
  assign hs       = busy & out_ready[sel];
  assign in_ready = (state == S_IDLE) | hs;
  assign accept   = in_valid & in_ready;

  // One-hot channel valid decode, one lane per destination
  for (genvar k = 0; k < 16; k++) begin : g_lane
    assign out_valid[k] = busy & (sel == 4'(k));
  end

`ifdef DEMUX_WDT_EN
  localparam int SW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [SW-1:0] stall_cnt;
  logic          wdt_fire;

  assign wdt_fire = busy & ~hs & (stall_cnt == SW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (accept || hs || wdt_fire || !busy) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + SW'(1);
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;
  logic wdt_fire;
  assign wdt_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      out_data <= '0;
      sel      <= '0;
      rr_ptr   <= '0;
      word_cnt <= '0;
      drop     <= 1'b0;
    end else begin
      drop <= 1'b0;
      if (hs) word_cnt <= word_cnt + 16'd1;
      if (accept) begin
        state    <= S_DRIVE;
        out_data <= in_data;
        sel      <= mode ? rr_ptr : in_dest;
        if (mode) rr_ptr <= rr_ptr + 4'd1;
      end else if (hs) begin
        state <= S_IDLE;
      end else if (wdt_fire) begin
        // Last valid cycle of a stalled word; discard and flag it
        state <= S_IDLE;
        drop  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_demux16_route_ctrl.sv
// Scoreboard bench for demux16_route_ctrl: accepts push expected {channel,data}, handshakes pop and compare.
module tb_demux16_route_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic [3:0]  in_dest = '0;
  logic        mode = 1'b0;
  logic [15:0] out_valid;
  logic [15:0] out_ready = '1;
  logic [7:0]  out_data;
  logic [3:0]  sel;
  logic        busy;
  logic [15:0] word_cnt;
  logic        drop;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] ch;
    logic [7:0] d;
  } exp_t;

  exp_t        sb_q[$];
  logic [3:0]  rr_m;
  logic [15:0] cnt_m;

  demux16_route_ctrl #(.DW(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dest(in_dest), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sel(sel), .busy(busy), .word_cnt(word_cnt), .drop(drop)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor, sampled on the falling edge while inputs are stable
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      rr_m  = 4'd0;
      cnt_m = 16'd0;
    end else begin
      if (in_valid && in_ready) begin
        sb_q.push_back({(mode ? rr_m : in_dest), in_data});
        if (mode) rr_m = rr_m + 4'd1;
      end
      if ((out_valid & out_ready) != 16'h0) begin
        exp_t e;
        logic [15:0] ev;
        checks++;
        if (sb_q.size() < 2 && !(sb_q.size() == 1 && !(in_valid && in_ready))) begin
          errors++;
          $display("FAIL sb_underflow: handshake with out_valid=%h but no word expected", out_valid);
        end else begin
          e  = sb_q.pop_front();
          ev = 16'h1 << e.ch;
          if (out_valid !== ev || out_data !== e.d) begin
            errors++;
            $display("FAIL sb_word: got valid=%h data=%h expected valid=%h data=%h",
                     out_valid, out_data, ev, e.d);
          end
        end
        cnt_m = cnt_m + 16'd1;
      end
      if (drop && sb_q.size() > 0) void'(sb_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++;
    if (out_valid !== 16'h0 || sel !== 4'h0 || word_cnt !== 16'h0 || busy !== 1'b0 || drop !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: valid=%h sel=%h cnt=%h busy=%b drop=%b required all 0",
               out_valid, sel, word_cnt, busy, drop);
    end
    rst_n = 1'b1;
    #1;
    // Park a word on channel 5 then reset in the middle of DRIVE
    mode = 1'b0; out_ready = 16'h0; in_valid = 1'b1; in_dest = 4'd5; in_data = 8'h55;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (sel !== 4'd5 || out_valid !== 16'h0020) begin
      errors++;
      $display("FAIL reset_pre: sel=%h valid=%h required sel=5 valid=0020", sel, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 16'h0 || sel !== 4'h0 || word_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid: valid=%h sel=%h cnt=%h required 0", out_valid, sel, word_cnt);
    end
    tick(); tick();
    rst_n = 1'b1;
    out_ready = '1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_addressed();
    mode = 1'b0; out_ready = '1;
    in_valid = 1'b1; in_data = 8'hA5; in_dest = 4'd9;
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 16'h0200 || out_data !== 8'hA5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL addr_out: valid=%h data=%h busy=%b required 0200 a5 1", out_valid, out_data, busy);
    end
    tick();
    checks++;
    if (word_cnt !== 16'd1 || out_valid !== 16'h0) begin
      errors++;
      $display("FAIL addr_cnt: cnt=%0d valid=%h required 1 0000", word_cnt, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] base;
    base = cnt_m;
    mode = 1'b0; out_ready = '1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_dest = 4'(i); in_data = 8'(8'h10 + i);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready: word %0d in_ready=%b required 1", i, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== (16'h1 << i)) begin
        errors++;
        $display("FAIL b2b_walk: word %0d valid=%h required %h", i, out_valid, 16'h1 << i);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (word_cnt !== base + 16'd16 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_cnt: cnt=%0d busy=%b required %0d 0", word_cnt, busy, base + 16'd16);
    end
  endtask

  task automatic test_round_robin();
    mode = 1'b1; out_ready = '1; in_dest = 4'd7;
    for (int i = 0; i < 18; i++) begin
      in_valid = 1'b1; in_data = 8'(8'hC0 + i);
      tick();
      checks++;
      if (sel !== 4'(i % 16)) begin
        errors++;
        $display("FAIL rr_sel: word %0d sel=%0d required %0d", i, sel, i % 16);
      end
    end
    in_valid = 1'b0;
    mode = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    mode = 1'b0; out_ready = ~16'h0008;
    in_valid = 1'b1; in_dest = 4'd3; in_data = 8'h3C;
    tick();
    in_dest = 4'd4; in_data = 8'h77;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (out_valid !== 16'h0008 || out_data !== 8'h3C || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d valid=%h data=%h in_ready=%b required 0008 3c 0",
                 c, out_valid, out_data, in_ready);
      end
      tick();
    end
    out_ready = '1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 16'h0010 || out_data !== 8'h77) begin
      errors++;
      $display("FAIL bp_next: valid=%h data=%h required 0010 77", out_valid, out_data);
    end
    tick();
  endtask

  task automatic test_wdt();
    logic [15:0] cnt0;
    int n;
    cnt0 = word_cnt;
    mode = 1'b0; out_ready = 16'h0;
    in_valid = 1'b1; in_dest = 4'd2; in_data = 8'h2D;
    tick();
    in_valid = 1'b0;
    n = 0;
`ifdef DEMUX_WDT_EN
    while (out_valid === 16'h0004 && n < 40) begin
      n++;
      tick();
    end
    checks++;
    if (n != 16 || drop !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wdt_fire: valid cycles=%0d drop=%b busy=%b required 16 1 0", n, drop, busy);
    end
    tick();
    checks++;
    if (drop !== 1'b0 || word_cnt !== cnt0) begin
      errors++;
      $display("FAIL wdt_after: drop=%b cnt=%0d required 0 %0d", drop, word_cnt, cnt0);
    end
    out_ready = '1;
`else
    while (out_valid === 16'h0004 && drop === 1'b0 && n < 110) begin
      n++;
      tick();
    end
    checks++;
    if (n != 110 || word_cnt !== cnt0) begin
      errors++;
      $display("FAIL wdt_hold: held cycles=%0d cnt=%0d required 110 %0d", n, word_cnt, cnt0);
    end
    out_ready = '1;
    tick();
    checks++;
    if (word_cnt !== cnt0 + 16'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wdt_flush: cnt=%0d busy=%b required %0d 0", word_cnt, busy, cnt0 + 16'd1);
    end
`endif
  endtask

  initial begin
    test_reset();
    do_reset();
    test_addressed();
    test_back_to_back();
    test_round_robin();
    test_backpressure();
    test_wdt();
    tick();
    checks++;
    if (sb_q.size() != 0 || word_cnt !== cnt_m) begin
      errors++;
      $display("FAIL sb_final: pending=%0d cnt=%0d required 0 %0d", sb_q.size(), word_cnt, cnt_m);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
